// File: rtl/fmul_pipe_hs.sv
// fmul_pipe_hs: 3-stage floating-point multiplier with valid/ready handshakes,
// a pass-through tag and {NV,OF,UF,NX} exception flags. Subnormals flush to zero.
module fmul_pipe_hs #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] op1,
    input  logic [EXP_W+MAN_W:0] op2,
    input  logic [1:0]           opc,
    input  logic [1:0]           r_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int DATA_W = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int XW     = EXP_W + 2;

    localparam logic [XW-1:0] BIAS    = XW'((2 ** (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EXP_OVF = XW'((2 ** EXP_W) - 1);

    localparam logic [1:0] OPC_MUL  = 2'b00;
    localparam logic [1:0] OPC_NMUL = 2'b01;
    localparam logic [1:0] OPC_AMUL = 2'b10;
    localparam logic [1:0] OPC_IDLE = 2'b11;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;

    localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Whole pipeline advances together; a stalled output freezes every stage.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en & rst_n;

    // ---------------------------------------------------------------- stage 1
    logic               a_sign, b_sign;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_frac, b_frac;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

    assign a_sign = op1[DATA_W-1];
    assign b_sign = op2[DATA_W-1];
    assign a_exp  = op1[DATA_W-2 -: EXP_W];
    assign b_exp  = op2[DATA_W-2 -: EXP_W];
    assign a_frac = op1[MAN_W-1:0];
    assign b_frac = op2[MAN_W-1:0];

    // Zero exponent covers both true zero and subnormals (flushed).
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == '1) && (a_frac == '0);
    assign b_inf  = (b_exp == '1) && (b_frac == '0);
    assign a_nan  = (a_exp == '1) && (a_frac != '0);
    assign b_nan  = (b_exp == '1) && (b_frac != '0);
    assign a_snan = a_nan & ~a_frac[MAN_W-1];
    assign b_snan = b_nan & ~b_frac[MAN_W-1];

    logic               s1_valid_d;
    logic               s1_sign_d;
    logic [XW-1:0]      s1_exp_d;
    logic               s1_spec_d;
    logic [DATA_W-1:0]  s1_spec_res_d;
    logic [3:0]         s1_spec_flags_d;

    // Classify operands, resolve special cases and form the biased exponent sum.
    always_comb begin
        s1_valid_d = in_valid & in_ready & (opc != OPC_IDLE);
        s1_sign_d  = 1'b0;
        unique case (opc)
            OPC_MUL:  s1_sign_d = a_sign ^ b_sign;
            OPC_NMUL: s1_sign_d = ~(a_sign ^ b_sign);
            OPC_AMUL: s1_sign_d = 1'b0;
            default:  s1_sign_d = 1'b0;
        endcase
        s1_exp_d        = {2'b00, a_exp} + {2'b00, b_exp} - BIAS;
        s1_spec_d       = 1'b0;
        s1_spec_res_d   = '0;
        s1_spec_flags_d = '0;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            s1_spec_d       = 1'b1;
            s1_spec_res_d   = QNAN;
            s1_spec_flags_d = {a_snan | b_snan | (a_inf & b_zero) | (b_inf & a_zero), 3'b000};
        end else if (a_inf | b_inf) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {s1_sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {s1_sign_d, {(DATA_W-1){1'b0}}};
        end
    end

    logic               s1_valid_q;
    logic               s1_sign_q;
    logic [XW-1:0]      s1_exp_q;
    logic [SIG_W-1:0]   s1_sig_a_q, s1_sig_b_q;
    logic               s1_spec_q;
    logic [DATA_W-1:0]  s1_spec_res_q;
    logic [3:0]         s1_spec_flags_q;
    logic [1:0]         s1_rm_q;
    logic [TAG_W-1:0]   s1_tag_q;

    // Stage 1 payload register.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign_q       <= s1_sign_d;
            s1_exp_q        <= s1_exp_d;
            s1_sig_a_q      <= {1'b1, a_frac};
            s1_sig_b_q      <= {1'b1, b_frac};
            s1_spec_q       <= s1_spec_d;
            s1_spec_res_q   <= s1_spec_res_d;
            s1_spec_flags_q <= s1_spec_flags_d;
            s1_rm_q         <= r_mode;
            s1_tag_q        <= in_tag;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [PROD_W-1:0]  prod;
    logic [SIG_W-1:0]   s2_mant_d;
    logic [XW-1:0]      s2_exp_d;
    logic               s2_guard_d, s2_round_d, s2_sticky_d;

    // Significand product; a product in [2,4) is renormalised by one place.
    always_comb begin
        prod = PROD_W'(s1_sig_a_q) * PROD_W'(s1_sig_b_q);
        if (prod[PROD_W-1]) begin
            s2_mant_d   = prod[PROD_W-1 -: SIG_W];
            s2_guard_d  = prod[MAN_W];
            s2_round_d  = prod[MAN_W-1];
            s2_sticky_d = |prod[MAN_W-2:0];
        end else begin
            s2_mant_d   = prod[PROD_W-2 -: SIG_W];
            s2_guard_d  = prod[MAN_W-1];
            s2_round_d  = prod[MAN_W-2];
            s2_sticky_d = |prod[MAN_W-3:0];
        end
        s2_exp_d = s1_exp_q + {{(XW-1){1'b0}}, prod[PROD_W-1]};
    end

    logic               s2_valid_q;
    logic               s2_sign_q;
    logic [XW-1:0]      s2_exp_q;
    logic [SIG_W-1:0]   s2_mant_q;
    logic               s2_guard_q, s2_round_q, s2_sticky_q;
    logic               s2_spec_q;
    logic [DATA_W-1:0]  s2_spec_res_q;
    logic [3:0]         s2_spec_flags_q;
    logic [1:0]         s2_rm_q;
    logic [TAG_W-1:0]   s2_tag_q;

    // Stage 2 payload register.
    always_ff @(posedge clk) begin
        if (en) begin
            s2_sign_q       <= s1_sign_q;
            s2_exp_q        <= s2_exp_d;
            s2_mant_q       <= s2_mant_d;
            s2_guard_q      <= s2_guard_d;
            s2_round_q      <= s2_round_d;
            s2_sticky_q     <= s2_sticky_d;
            s2_spec_q       <= s1_spec_q;
            s2_spec_res_q   <= s1_spec_res_q;
            s2_spec_flags_q <= s1_spec_flags_q;
            s2_rm_q         <= s1_rm_q;
            s2_tag_q        <= s1_tag_q;
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic               grs;
    logic               round_up;
    logic [SIG_W:0]     mant_rnd;
    logic               carry;
    logic [XW-1:0]      exp_rnd;
    logic [MAN_W-1:0]   frac_rnd;
    logic               ovf, unf;
    logic [DATA_W-1:0]  inf_val, max_val;
    logic [DATA_W-1:0]  res_d;
    logic [3:0]         flags_d;

    // Directed rounding on the final sign, then overflow/underflow saturation.
    always_comb begin
        grs      = s2_guard_q | s2_round_q | s2_sticky_q;
        round_up = 1'b0;
        unique case (s2_rm_q)
            RM_RNE:  round_up = s2_guard_q & (s2_round_q | s2_sticky_q | s2_mant_q[0]);
            RM_RTZ:  round_up = 1'b0;
            RM_RUP:  round_up = ~s2_sign_q & grs;
            default: round_up = s2_sign_q & grs;
        endcase
        mant_rnd = {1'b0, s2_mant_q} + {{SIG_W{1'b0}}, round_up};
        carry    = mant_rnd[SIG_W];
        exp_rnd  = s2_exp_q + {{(XW-1){1'b0}}, carry};
        frac_rnd = carry ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
        ovf      = ~exp_rnd[XW-1] && (exp_rnd >= EXP_OVF);
        unf      = exp_rnd[XW-1] || (exp_rnd == '0);
        inf_val  = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        max_val  = {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

        res_d   = {s2_sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
        flags_d = {3'b000, grs};
        if (s2_spec_q) begin
            res_d   = s2_spec_res_q;
            flags_d = s2_spec_flags_q;
        end else if (ovf) begin
            flags_d = 4'b0101;
            unique case (s2_rm_q)
                RM_RNE:  res_d = inf_val;
                RM_RTZ:  res_d = max_val;
                RM_RUP:  res_d = s2_sign_q ? max_val : inf_val;
                default: res_d = s2_sign_q ? inf_val : max_val;
            endcase
        end else if (unf) begin
            res_d   = {s2_sign_q, {(DATA_W-1){1'b0}}};
            flags_d = 4'b0011;
        end
    end

    // Stage valid bits; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_valid  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s1_valid_q;
            out_valid  <= s2_valid_q;
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result  <= '0;
            flags   <= '0;
            out_tag <= '0;
        end else if (en && s2_valid_q) begin
            result  <= res_d;
            flags   <= flags_d;
            out_tag <= s2_tag_q;
        end
    end

endmodule

// File: tb/tb_fmul_pipe_hs.sv
// Self-checking bench for fmul_pipe_hs (binary32 default parameters).
module tb_fmul_pipe_hs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1, op2;
    logic [1:0]  opc, r_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [3:0]  out_tag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fmul_pipe_hs #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .opc       (opc),
        .r_mode    (r_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .out_tag   (out_tag)
    );

    // Reference: exact integer product, then rounding by comparing the discarded
    // remainder with one half ulp. Returns {result, flags}.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op, input logic [1:0] rm);
        logic        sa, sb, sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, snan, inf0;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic [63:0] p, q, rem, half;
        logic        up, inexact;
        int          e, sh;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        a_zero = (ea == 8'd0);  b_zero = (eb == 8'd0);
        a_inf = (ea == 8'hFF) && (fa == 23'd0);
        b_inf = (eb == 8'hFF) && (fb == 23'd0);
        a_nan = (ea == 8'hFF) && (fa != 23'd0);
        b_nan = (eb == 8'hFF) && (fb != 23'd0);
        snan = (a_nan && !fa[22]) || (b_nan && !fb[22]);
        inf0 = (a_inf && b_zero) || (b_inf && a_zero);
        sgn = (op == 2'b00) ? (sa ^ sb) : (op == 2'b01) ? !(sa ^ sb) : 1'b0;
        if (a_nan || b_nan || inf0) return {32'h7FC00000, (snan || inf0), 3'b000};
        if (a_inf || b_inf) return {sgn, 8'hFF, 23'd0, 4'b0000};
        if (a_zero || b_zero) return {sgn, 31'd0, 4'b0000};
        p = {40'd0, 1'b1, fa} * {40'd0, 1'b1, fb};
        e = int'(ea) + int'(eb) - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e = e + 1;
        end else begin
            sh = 23;
        end
        q = p >> sh;
        rem = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inexact = (rem != 64'd0);
        case (rm)
            2'b00:   up = (rem > half) || ((rem == half) && q[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = !sgn && inexact;
            default: up = sgn && inexact;
        endcase
        q = q + {63'd0, up};
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            case (rm)
                2'b00:   return {sgn, 8'hFF, 23'd0, 4'b0101};
                2'b01:   return {sgn, 8'hFE, 23'h7FFFFF, 4'b0101};
                2'b10:   return sgn ? {1'b1, 8'hFE, 23'h7FFFFF, 4'b0101}
                                    : {1'b0, 8'hFF, 23'd0, 4'b0101};
                default: return sgn ? {1'b1, 8'hFF, 23'd0, 4'b0101}
                                    : {1'b0, 8'hFE, 23'h7FFFFF, 4'b0101};
            endcase
        end
        if (e <= 0) return {sgn, 31'd0, 4'b0011};
        return {sgn, 8'(e), q[22:0], 3'b000, inexact};
    endfunction

    // Operand generator biased towards specials and exponent extremes.
    function automatic logic [31:0] gen_op();
        int unsigned c;
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        c = $urandom_range(0, 15);
        f = 23'($urandom);
        s = 1'($urandom);
        case (c)
            0:       begin e = 8'd0; f = 23'd0; end
            1:       e = 8'd0;
            2:       begin e = 8'hFF; f = 23'd0; end
            3:       begin e = 8'hFF; f[22] = 1'b1; end
            4:       begin e = 8'hFF; f[22] = 1'b0; f[0] = 1'b1; end
            5, 6:    e = 8'($urandom_range(1, 30));
            7, 8:    e = 8'($urandom_range(225, 254));
            9:       begin e = 8'($urandom_range(100, 154)); f = 23'($urandom_range(0, 3)); end
            10:      begin e = 8'($urandom_range(100, 154)); f = 23'h7FFFFF ^ 23'($urandom_range(0, 3)); end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, f};
    endfunction

    function automatic logic [103:0] dir_vec(input int i);
        // {a, b, opc, rm, expected result, expected flags}
        case (i)
            0:  return {32'h3FC00000, 32'h40000000, 2'b00, 2'b00, 32'h40400000, 4'h0};
            1:  return {32'h3F800001, 32'h40400000, 2'b00, 2'b00, 32'h40400002, 4'h1};
            2:  return {32'h3F800001, 32'h40400000, 2'b00, 2'b01, 32'h40400001, 4'h1};
            3:  return {32'h7F800000, 32'h00000000, 2'b00, 2'b00, 32'h7FC00000, 4'h8};
            4:  return {32'h7F800000, 32'h3F800000, 2'b01, 2'b00, 32'hFF800000, 4'h0};
            5:  return {32'h7F7FFFFF, 32'h40000000, 2'b00, 2'b01, 32'h7F7FFFFF, 4'h5};
            6:  return {32'h7F7FFFFF, 32'h40000000, 2'b00, 2'b00, 32'h7F800000, 4'h5};
            7:  return {32'h00800000, 32'h3F000000, 2'b00, 2'b00, 32'h00000000, 4'h3};
            8:  return {32'hBF800000, 32'h40000000, 2'b10, 2'b00, 32'h40000000, 4'h0};
            9:  return {32'hFF7FFFFF, 32'h40000000, 2'b00, 2'b10, 32'hFF7FFFFF, 4'h5};
            10: return {32'hFF7FFFFF, 32'h40000000, 2'b00, 2'b11, 32'hFF800000, 4'h5};
            11: return {32'h7F800001, 32'h3F800000, 2'b00, 2'b00, 32'h7FC00000, 4'h8};
            12: return {32'h00000001, 32'h3F800000, 2'b01, 2'b00, 32'h80000000, 4'h0};
            13: return {32'hBF800001, 32'h40400000, 2'b00, 2'b11, 32'hC0400002, 4'h1};
            14: return {32'h7FC00000, 32'hBF800000, 2'b01, 2'b00, 32'h7FC00000, 4'h0};
            default: return {32'hFF800000, 32'h7F800000, 2'b00, 2'b00, 32'hFF800000, 4'h0};
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; opc = 2'b00; r_mode = 2'b00; in_tag = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (result !== 32'd0) begin
            miscompares++; $display("FAIL reset_result: got %h want 0", result);
        end
        vectors++;
        if (flags !== 4'd0) begin
            miscompares++; $display("FAIL reset_flags: got %b want 0000", flags);
        end
        vectors++;
        if (out_tag !== 4'd0) begin
            miscompares++; $display("FAIL reset_tag: got %h want 0", out_tag);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [103:0] v;
        logic [3:0]   tg;
        int           lat;
        for (int i = 0; i < 16; i++) begin
            v = dir_vec(i);
            tg = (i == 0) ? 4'd5 : 4'(i);
            @(negedge clk);
            op1 = v[103:72]; op2 = v[71:40]; opc = v[39:38]; r_mode = v[37:36];
            in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            vectors++;
            if (lat !== 3) begin
                miscompares++; $display("FAIL dir%0d_latency: got %0d want 3", i, lat);
            end
            vectors++;
            if (result !== v[35:4]) begin
                miscompares++; $display("FAIL dir%0d_result: got %h want %h", i, result, v[35:4]);
            end
            vectors++;
            if (flags !== v[3:0]) begin
                miscompares++; $display("FAIL dir%0d_flags: got %b want %b", i, flags, v[3:0]);
            end
            vectors++;
            if (out_tag !== tg) begin
                miscompares++; $display("FAIL dir%0d_tag: got %h want %h", i, out_tag, tg);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [39:0] q[$];
        logic [39:0] e;
        logic [35:0] m;
        logic        prev_stall = 1'b0;
        logic [31:0] pr = '0;
        logic [3:0]  pf = '0, pt = '0;
        int          sent = 0, cyc = 0;
        while ((sent < n || q.size() != 0) && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = (sent < n) && ($urandom_range(0, 4) != 0);
            op1 = gen_op(); op2 = gen_op();
            opc = 2'($urandom); r_mode = 2'($urandom); in_tag = 4'($urandom);
            #1;
            if (prev_stall) begin
                vectors++;
                if (!(out_valid === 1'b1 && result === pr && flags === pf && out_tag === pt)) begin
                    miscompares++;
                    $display("FAIL rnd_hold: got v=%b %h/%b/%h want v=1 %h/%b/%h",
                             out_valid, result, flags, out_tag, pr, pf, pt);
                end
            end
            prev_stall = out_valid && !out_ready;
            pr = result; pf = flags; pt = out_tag;
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_unexpected: got %h/%b/%h want nothing", result, flags, out_tag);
                end else begin
                    e = q.pop_front();
                    if ({result, flags, out_tag} !== e) begin
                        miscompares++;
                        $display("FAIL rnd_result: got %h/%b/%h want %h/%b/%h",
                                 result, flags, out_tag, e[39:8], e[7:4], e[3:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sent++;
                if (opc != 2'b11) begin
                    m = ref_mul(op1, op2, opc, r_mode);
                    q.push_back({m, in_tag});
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        vectors++;
        if (sent != n || q.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_drain: got sent=%0d pending=%0d want sent=%0d pending=0",
                     sent, q.size(), n);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[6], b[6];
        logic [1:0]  o[6], r[6];
        logic [39:0] q[$];
        logic [39:0] e;
        logic        held = 1'b0;
        logic [31:0] hres = '0;
        logic [3:0]  htag = '0;
        int          sent = 0, got = 0, cyc = 0, first = -1, stall_n = 0, extra = 0;
        for (int i = 0; i < 6; i++) begin
            a[i] = gen_op(); b[i] = gen_op();
            o[i] = 2'($urandom_range(0, 2)); r[i] = 2'($urandom);
        end
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            if (first < 0 && out_valid) first = cyc;
            out_ready = !(first >= 0 && cyc < first + 4);
            in_valid = (sent < 6);
            if (sent < 6) begin
                op1 = a[sent]; op2 = b[sent]; opc = o[sent]; r_mode = r[sent];
                in_tag = 4'(sent + 8);
            end
            #1;
            if (out_valid && !out_ready) begin
                stall_n++;
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_in_ready: got %b want 0", in_ready);
                end
                if (held) begin
                    vectors++;
                    if (result !== hres || out_tag !== htag) begin
                        miscompares++;
                        $display("FAIL b2b_hold: got %h/%h want %h/%h", result, out_tag, hres, htag);
                    end
                end
                held = 1'b1; hres = result; htag = out_tag;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                vectors++;
                e = (q.size() != 0) ? q.pop_front() : 40'd0;
                if ({result, flags, out_tag} !== e) begin
                    miscompares++;
                    $display("FAIL b2b_result%0d: got %h/%b/%h want %h/%b/%h", got,
                             result, flags, out_tag, e[39:8], e[7:4], e[3:0]);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back({ref_mul(op1, op2, opc, r_mode), in_tag});
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        vectors++;
        if (got != 6) begin
            miscompares++; $display("FAIL b2b_count: got %0d want 6", got);
        end
        vectors++;
        if (stall_n != 4) begin
            miscompares++; $display("FAIL b2b_stall_cycles: got %0d want 4", stall_n);
        end
        repeat (5) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++; $display("FAIL b2b_duplicate: got %0d extra outputs want 0", extra);
        end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            op1 = 32'h3FC00000; op2 = 32'h40000000; opc = 2'b00; r_mode = 2'b00;
            in_tag = 4'(i + 1); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++; $display("FAIL rst_stale: got %0d outputs want 0", seen);
        end
    endtask

    task automatic test_idle();
        logic [31:0] a[3], b[3];
        logic [1:0]  o[3];
        logic [39:0] ex[2];
        int          got = 0;
        a[0] = 32'h3FC00000; b[0] = 32'h40000000; o[0] = 2'b00;
        a[1] = 32'h40000000; b[1] = 32'h40000000; o[1] = 2'b11;
        a[2] = 32'h40400000; b[2] = 32'h40400000; o[2] = 2'b01;
        ex[0] = {32'h40400000, 4'h0, 4'h1};
        ex[1] = {32'hC1100000, 4'h0, 4'h3};
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            in_valid = (k < 3);
            if (k < 3) begin
                op1 = a[k]; op2 = b[k]; opc = o[k]; r_mode = 2'b00; in_tag = 4'(k + 1);
            end
            #1;
            if (k == 1) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++; $display("FAIL idle_accept: got %b want 1", in_ready);
                end
            end
            if (out_valid) begin
                if (got < 2) begin
                    vectors++;
                    if ({result, flags, out_tag} !== ex[got]) begin
                        miscompares++;
                        $display("FAIL idle_result%0d: got %h/%b/%h want %h/%b/%h", got,
                                 result, flags, out_tag, ex[got][39:8], ex[got][7:4], ex[got][3:0]);
                    end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (got != 2) begin
            miscompares++; $display("FAIL idle_count: got %0d want 2", got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(400);
        test_back_to_back();
        test_reset_inflight();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
